alu_seq: RTL and testbench

ALU_SEQ -- requirements
Module: alu_seq

---
 rtl/alu_pkg.sv | 38 +++
 rtl/alu_seq_if.sv | 42 ++++
 rtl/alu.sv | 68 ++++++
 rtl/alu_seq.sv | 118 +++++++++++
 tb/tb_alu_seq.sv | 276 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/alu_pkg.sv
// Shared types for the control-loop sequencer and its ALU: state encoding,
// operand-select encodings and the 12-bit signed saturation helper.
package alu_pkg;

   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_ERR  = 3'd1,
      ST_INTG = 3'd2,
      ST_ICMP = 3'd3,
      ST_PCMP = 3'd4,
      ST_ACC1 = 3'd5,
      ST_ACC2 = 3'd6
   } seq_state_e;

   typedef enum logic [2:0] {
      SRC0_A2D    = 3'b000,
      SRC0_INTGRL = 3'b001,
      SRC0_ICOMP  = 3'b010,
      SRC0_PCOMP  = 3'b011,
      SRC0_PTERM  = 3'b100
   } src0_sel_e;

   typedef enum logic [2:0] {
      SRC1_ACCUM     = 3'b000,
      SRC1_ITERM     = 3'b001,
      SRC1_ERROR     = 3'b010,
      SRC1_ERR_DIV16 = 3'b011,
      SRC1_FWD       = 3'b100
   } src1_sel_e;

   // Clamp a 17-bit signed sum into the signed 12-bit range, sign-extended to 16 bits.
   function automatic logic [15:0] sat_to_12(input logic [16:0] v);
      if (!v[16] && (|v[15:11])) return 16'h07FF;
      if (v[16] && !(&v[15:11])) return 16'hF800;
      return v[15:0];
   endfunction

endpackage

// File: rtl/alu_seq_if.sv
// Bus between the host, the control-loop sequencer (master) and the ALU (slave).
interface alu_seq_if;

   // strt is a request sampled only while the sequencer is idle (busy=0); there is
   // no backpressure. done is a one-cycle valid qualifying result; no ready exists.
   logic        strt;
   logic [15:0] target;
   logic [11:0] a2d_in;
   logic        clr_intgrl;
   logic [11:0] result;
   logic        busy;
   logic        done;

   logic [15:0] dst;
   logic [2:0]  src0sel;
   logic [2:0]  src1sel;
   logic        mult2;
   logic        mult4;
   logic        sub;
   logic        multiply;
   logic        saturate;
   logic [15:0] Accum;
   logic [15:0] Pcomp;
   logic [11:0] Error;
   logic [11:0] Intgrl;
   logic [11:0] Icomp;
   logic [11:0] A2D_res;

   modport master (
      input  strt, target, a2d_in, clr_intgrl, dst,
      output result, busy, done,
      output src0sel, src1sel, mult2, mult4, sub, multiply, saturate,
      output Accum, Pcomp, Error, Intgrl, Icomp, A2D_res
   );

   modport slave (
      input  src0sel, src1sel, mult2, mult4, sub, multiply, saturate,
      input  Accum, Pcomp, Error, Intgrl, Icomp, A2D_res,
      output dst
   );

endinterface

// File: rtl/alu.sv
// Combinational PI-loop ALU: operand muxes, scaled add/subtract with optional
// 12-bit saturation, and a signed multiply scaled down by 2^11.
module alu
   import alu_pkg::*;
(
   alu_seq_if.slave   bus,
   input  logic [11:0] iterm_i,
   input  logic [15:0] pterm_i,
   input  logic [11:0] fwd_i
);

   logic [15:0]        src1;
   logic [15:0]        src0;
   logic [15:0]        src0_scl;
   logic [16:0]        add_opnd;
   logic [16:0]        sum;
   logic [15:0]        add_res;
   logic [31:0]        prod;
   logic signed [31:0] mul_shift;
   logic [15:0]        mul_res;

   always_comb begin
      src1 = '0;
      case (bus.src1sel)
         SRC1_ACCUM:     src1 = bus.Accum;
         SRC1_ITERM:     src1 = {4'h0, iterm_i};
         SRC1_ERROR:     src1 = {{4{bus.Error[11]}}, bus.Error};
         SRC1_ERR_DIV16: src1 = {{8{bus.Error[11]}}, bus.Error[11:4]};
         SRC1_FWD:       src1 = {4'h0, fwd_i};
         default:        src1 = '0;
      endcase
   end

   always_comb begin
      src0 = '0;
      case (bus.src0sel)
         SRC0_A2D:    src0 = {4'h0, bus.A2D_res};
         SRC0_INTGRL: src0 = {{4{bus.Intgrl[11]}}, bus.Intgrl};
         SRC0_ICOMP:  src0 = {{4{bus.Icomp[11]}}, bus.Icomp};
         SRC0_PCOMP:  src0 = bus.Pcomp;
         SRC0_PTERM:  src0 = pterm_i;
         default:     src0 = '0;
      endcase
   end

   always_comb begin
      src0_scl = src0;
      if (bus.mult4)      src0_scl = {src0[13:0], 2'b00};
      else if (bus.mult2) src0_scl = {src0[14:0], 1'b0};
   end

   // Subtraction is src1 - src0 via inversion plus carry-in; 17 bits keep the true sign.
   assign add_opnd = bus.sub ? ~{src0_scl[15], src0_scl} : {src0_scl[15], src0_scl};
   assign sum      = {src1[15], src1} + add_opnd + {16'd0, bus.sub};
   assign add_res  = bus.saturate ? sat_to_12(sum) : sum[15:0];

   assign prod      = {{16{src1[15]}}, src1} * {{16{src0[15]}}, src0};
   assign mul_shift = $signed(prod) >>> 11;

   always_comb begin
      mul_res = mul_shift[15:0];
      if (!mul_shift[31] && (|mul_shift[30:15]))     mul_res = 16'h7FFF;
      else if (mul_shift[31] && !(&mul_shift[30:15])) mul_res = 16'h8000;
   end

   assign bus.dst = bus.multiply ? mul_res : add_res;

endmodule

// File: rtl/alu_seq.sv
// Control-loop sequencer: walks ERR..ACC2 once per accepted strt, steering the
// external ALU and capturing each intermediate into its own register.
module alu_seq
   import alu_pkg::*;
(
   input  logic       clk,
   input  logic       rst_n,
   alu_seq_if.master  bus,
   output seq_state_e state_o
);

   seq_state_e  state_q, state_d;
   logic [15:0] accum_q;
   logic [15:0] pcomp_q;
   logic [11:0] error_q;
   logic [11:0] intgrl_q;
   logic [11:0] icomp_q;
   logic [11:0] a2d_res_q;
   logic [11:0] result_q;
   logic        done_q;

   always_comb begin
      state_d      = state_q;
      bus.src0sel  = SRC0_A2D;
      bus.src1sel  = SRC1_ACCUM;
      bus.mult2    = 1'b0;
      bus.mult4    = 1'b0;
      bus.sub      = 1'b0;
      bus.multiply = 1'b0;
      bus.saturate = 1'b0;
      case (state_q)
         ST_IDLE: if (bus.strt) state_d = ST_ERR;
         ST_ERR: begin
            bus.src1sel  = SRC1_ACCUM;
            bus.src0sel  = SRC0_A2D;
            bus.sub      = 1'b1;
            bus.saturate = 1'b1;
            state_d      = ST_INTG;
         end
         ST_INTG: begin
            bus.src1sel  = SRC1_ERR_DIV16;
            bus.src0sel  = SRC0_INTGRL;
            bus.saturate = 1'b1;
            state_d      = ST_ICMP;
         end
         ST_ICMP: begin
            bus.src1sel  = SRC1_ITERM;
            bus.src0sel  = SRC0_INTGRL;
            bus.multiply = 1'b1;
            state_d      = ST_PCMP;
         end
         ST_PCMP: begin
            bus.src1sel  = SRC1_ERROR;
            bus.src0sel  = SRC0_PTERM;
            bus.multiply = 1'b1;
            state_d      = ST_ACC1;
         end
         ST_ACC1: begin
            bus.src1sel  = SRC1_FWD;
            bus.src0sel  = SRC0_PCOMP;
            state_d      = ST_ACC2;
         end
         ST_ACC2: begin
            bus.src1sel  = SRC1_ACCUM;
            bus.src0sel  = SRC0_ICOMP;
            bus.saturate = 1'b1;
            state_d      = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q   <= ST_IDLE;
         accum_q   <= '0;
         pcomp_q   <= '0;
         error_q   <= '0;
         intgrl_q  <= '0;
         icomp_q   <= '0;
         a2d_res_q <= '0;
         result_q  <= '0;
         done_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         done_q  <= (state_q == ST_ACC2);
         case (state_q)
            // Clear precedes a same-cycle start so INTG sees a zero integrator.
            ST_IDLE: begin
               if (bus.clr_intgrl) intgrl_q <= '0;
               if (bus.strt) begin
                  accum_q   <= bus.target;
                  a2d_res_q <= bus.a2d_in;
               end
            end
            ST_ERR:  error_q  <= bus.dst[11:0];
            ST_INTG: intgrl_q <= bus.dst[11:0];
            ST_ICMP: icomp_q  <= bus.dst[11:0];
            ST_PCMP: pcomp_q  <= bus.dst;
            ST_ACC1: accum_q  <= bus.dst;
            ST_ACC2: result_q <= bus.dst[11:0];
            default: ;
         endcase
      end
   end

   assign bus.Accum   = accum_q;
   assign bus.Pcomp   = pcomp_q;
   assign bus.Error   = error_q;
   assign bus.Intgrl  = intgrl_q;
   assign bus.Icomp   = icomp_q;
   assign bus.A2D_res = a2d_res_q;
   assign bus.result  = result_q;
   assign bus.done    = done_q;
   assign bus.busy    = (state_q != ST_IDLE);
   assign state_o     = state_q;

endmodule

// File: tb/tb_alu_seq.sv
// Bench for alu_seq driving a real alu: cycle reference model plus a result
// scoreboard, with directed timing, saturation, back-to-back and reset cases.
module tb_alu_seq;
   import alu_pkg::*;

   localparam int FWD = 0;

   typedef struct packed {
      logic [11:0] err;
      logic [11:0] intg;
      logic [11:0] icmp;
      logic [15:0] pcmp;
      logic [15:0] accum;
      logic [11:0] res;
   } txn_t;

   logic       clk;
   logic       rst_n;
   seq_state_e state;
   alu_seq_if  bus();

   alu_seq u_seq (.clk(clk), .rst_n(rst_n), .bus(bus), .state_o(state));
   alu     u_alu (.bus(bus), .iterm_i(12'h100), .pterm_i(16'h0800), .fwd_i(12'h000));

   // ---------------- clock / reset ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #100000;
      $display("FAIL timeout: bench did not reach its summary");
      $fatal(1, "timeout");
   end

   // ---------------- reference model ----------------
   int          n_checks = 0;
   int          n_fail   = 0;
   logic [11:0] exp_q[$];
   int          m_phase  = 0;
   logic [15:0] m_accum, m_pcomp;
   logic [11:0] m_err, m_intg, m_icomp, m_a2d, m_result;
   logic        m_done;
   txn_t        cur, nxt;

   function automatic int sat(int v, int lo, int hi);
      return (v < lo) ? lo : ((v > hi) ? hi : v);
   endfunction

   function automatic int s12(logic [11:0] v);
      return int'($signed(v));
   endfunction

   function automatic int s16(logic [15:0] v);
      return int'($signed(v));
   endfunction

   function automatic txn_t predict(logic [15:0] tgt, logic [11:0] a2d, logic [11:0] intg0);
      txn_t t;
      int   e, i, ic, p, acc, r;
      e   = sat(s16(tgt) - int'(a2d), -2048, 2047);
      i   = sat((e >>> 4) + s12(intg0), -2048, 2047);
      ic  = sat((i * 256) >>> 11, -32768, 32767);
      p   = sat((e * 2048) >>> 11, -32768, 32767);
      acc = p + FWD;
      t.err   = e[11:0];
      t.intg  = i[11:0];
      t.icmp  = ic[11:0];
      t.pcmp  = p[15:0];
      t.accum = acc[15:0];
      r       = sat(s16(t.accum) + s12(t.icmp), -2048, 2047);
      t.res   = r[11:0];
      return t;
   endfunction

   // {src1sel, src0sel, mult2, mult4, sub, multiply, saturate} for each phase
   function automatic logic [10:0] ctrl_exp(int ph);
      case (ph)
         1:       return {3'b000, 3'b000, 5'b00101};
         2:       return {3'b011, 3'b001, 5'b00001};
         3:       return {3'b001, 3'b001, 5'b00010};
         4:       return {3'b010, 3'b100, 5'b00010};
         5:       return {3'b100, 3'b011, 5'b00000};
         6:       return {3'b000, 3'b010, 5'b00001};
         default: return 11'd0;
      endcase
   endfunction

   always @(posedge clk) begin
      if (!rst_n) begin
         m_phase  <= 0;
         m_accum  <= '0;
         m_pcomp  <= '0;
         m_err    <= '0;
         m_intg   <= '0;
         m_icomp  <= '0;
         m_a2d    <= '0;
         m_result <= '0;
         m_done   <= 1'b0;
         exp_q.delete();
      end else begin
         m_done <= (m_phase == 6);
         case (m_phase)
            0: begin
               if (bus.clr_intgrl) m_intg <= '0;
               if (bus.strt) begin
                  nxt = predict(bus.target, bus.a2d_in, bus.clr_intgrl ? 12'h000 : m_intg);
                  cur <= nxt;
                  exp_q.push_back(nxt.res);
                  m_accum <= bus.target;
                  m_a2d   <= bus.a2d_in;
                  m_phase <= 1;
               end
            end
            1: begin m_err    <= cur.err;   m_phase <= 2; end
            2: begin m_intg   <= cur.intg;  m_phase <= 3; end
            3: begin m_icomp  <= cur.icmp;  m_phase <= 4; end
            4: begin m_pcomp  <= cur.pcmp;  m_phase <= 5; end
            5: begin m_accum  <= cur.accum; m_phase <= 6; end
            default: begin m_result <= cur.res; m_phase <= 0; end
         endcase
      end
   end

   // ---------------- checking ----------------
   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=0x%0h exp=0x%0h t=%0t", tag, got, exp, $time);
      end
   endtask

   // Advance to the next falling edge and compare every observable against the model.
   task automatic cycle();
      @(negedge clk);
      check("state", 32'(state), 32'(m_phase));
      check("busy", bus.busy, m_phase != 0);
      check("done", bus.done, m_done);
      check("ctrl", {bus.src1sel, bus.src0sel, bus.mult2, bus.mult4, bus.sub,
                     bus.multiply, bus.saturate}, ctrl_exp(m_phase));
      check("Accum", bus.Accum, m_accum);
      check("Pcomp", bus.Pcomp, m_pcomp);
      check("Error", bus.Error, m_err);
      check("Intgrl", bus.Intgrl, m_intg);
      check("Icomp", bus.Icomp, m_icomp);
      check("A2D_res", bus.A2D_res, m_a2d);
      check("result", bus.result, m_result);
      if (bus.done) begin
         check("sb_pending", 32'(exp_q.size() != 0), 1);
         if (exp_q.size() != 0) check("sb_result", bus.result, exp_q.pop_front());
      end
   endtask

   task automatic run_err(input logic [15:0] tgt, input logic [11:0] a2d, input logic [11:0] exp_err);
      bus.target = tgt;
      bus.a2d_in = a2d;
      bus.strt   = 1'b1;
      cycle();
      bus.strt = 1'b0;
      cycle();
      check("err_value", bus.Error, exp_err);
      repeat (6) cycle();
   endtask

   // ---------------- stimulus ----------------
   int cnt;
   int gap;

   initial begin
      rst_n          = 1'b0;
      bus.strt       = 1'b1;
      bus.target     = 16'hABCD;
      bus.a2d_in     = 12'h123;
      bus.clr_intgrl = 1'b1;
      repeat (2) cycle();
      check("rst_busy", bus.busy, 0);
      check("rst_done", bus.done, 0);
      check("rst_result", bus.result, 0);

      // First request right at reset release; directed timing points.
      rst_n          = 1'b1;
      bus.clr_intgrl = 1'b0;
      bus.target     = 16'h0100;
      bus.a2d_in     = 12'h080;
      cycle();
      check("n1_busy", bus.busy, 1);
      bus.strt = 1'b0;
      cycle();
      check("n2_error", bus.Error, 12'h080);
      cycle();
      check("n3_intgrl", bus.Intgrl, 12'h008);
      repeat (3) begin
         cycle();
         check("n4_6_done_low", bus.done, 0);
      end
      cycle();
      check("n7_done", bus.done, 1);
      check("n7_busy", bus.busy, 0);
      check("n7_result", bus.result, 12'h081);
      cycle();
      check("n8_done_low", bus.done, 0);

      // Error saturation, both directions.
      run_err(16'h1000, 12'h000, 12'h7FF);
      run_err(16'hF000, 12'h000, 12'h800);

      // Random requests, with strt also toggled while busy.
      repeat (10) begin
         bus.target     = 16'($urandom_range(0, 65535));
         bus.a2d_in     = 12'($urandom_range(0, 4095));
         bus.clr_intgrl = ($urandom_range(0, 3) == 0);
         bus.strt       = 1'b1;
         cycle();
         bus.clr_intgrl = 1'b0;
         gap = $urandom_range(6, 9);
         for (int k = 0; k < gap; k++) begin
            bus.strt = ($urandom_range(0, 2) == 0);
            cycle();
         end
      end
      bus.strt = 1'b0;
      repeat (8) cycle();

      // strt held high: one start every 7 cycles.
      bus.strt = 1'b1;
      cnt = 0;
      repeat (28) begin
         bus.target = 16'($urandom_range(0, 65535));
         bus.a2d_in = 12'($urandom_range(0, 4095));
         cycle();
         if (bus.done) cnt++;
      end
      check("held_done_count", cnt, 4);
      bus.strt = 1'b0;
      repeat (8) cycle();

      // Reset while in ICMP discards the computation.
      bus.target = 16'h0300;
      bus.a2d_in = 12'h010;
      bus.strt   = 1'b1;
      cycle();
      bus.strt = 1'b0;
      repeat (2) cycle();
      check("pre_rst_state", 32'(state), 32'(ST_ICMP));
      rst_n = 1'b0;
      cycle();
      check("post_rst_state", 32'(state), 32'(ST_IDLE));
      check("post_rst_error", bus.Error, 0);
      rst_n = 1'b1;
      cnt = 0;
      repeat (8) begin
         cycle();
         if (bus.done) cnt++;
      end
      check("rst_no_done", cnt, 0);

      // Build up the integrator, then clear it together with a new start.
      run_err(16'h0400, 12'h000, 12'h400);
      check("intgrl_built", bus.Intgrl, 12'h040);
      bus.target     = 16'h0100;
      bus.a2d_in     = 12'h080;
      bus.strt       = 1'b1;
      bus.clr_intgrl = 1'b1;
      cycle();
      bus.strt       = 1'b0;
      bus.clr_intgrl = 1'b0;
      repeat (2) cycle();
      check("clr_intgrl", bus.Intgrl, 12'h008);
      repeat (5) cycle();

      check("sb_drained", exp_q.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
